alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq.sv | 149 ++++++++++++++
 tb/tb_alu_seq.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for alu_seq.
//   slave  : seen by the ALU (inputs: request fields, out_ready; outputs: in_ready, result, flags)
//   master : seen by the requester/consumer (mirror image of slave)
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             A_invert;
    logic             B_invert;
    logic             cin;
    logic [2:0]       operation;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             overflow;

    modport slave (
        input  in_valid, src1, src2, A_invert, B_invert, cin, operation, out_ready,
        output in_ready, out_valid, result, cout, zero, overflow
    );

    modport master (
        output in_valid, src1, src2, A_invert, B_invert, cin, operation, out_ready,
        input  in_ready, out_valid, result, cout, zero, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready request and response handshakes.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : alu_seq_if.slave -- request (in_valid/in_ready, src1, src2, A_invert, B_invert,
//          cin, operation) and response (out_valid/out_ready, result, cout, zero, overflow)
// Ops: 000 AND, 001 OR, 010 ADD, 011 SLT, 100 MUL (iterative, if MUL_EN), others -> 0.
// Single-cycle ops present their result the cycle after acceptance; MUL spends WIDTH
// cycles in a shift-add loop first.
module alu_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned MUL_EN = 1
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0]   a, b;
    logic [WIDTH:0]     sum;
    logic               add_ovf;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cout, alu_ovf;
    logic [2*WIDTH-1:0] acc_step;
    logic               is_mul;

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;

    assign is_mul   = (MUL_EN != 0) && (bus.operation == 3'b100);
    // One partial-product bit per CALC cycle: multiplier LSB selects the shifted multiplicand.
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Single-cycle datapath, evaluated on the live request inputs at acceptance.
    always_comb begin
        a        = bus.A_invert ? ~bus.src1 : bus.src1;
        b        = bus.B_invert ? ~bus.src2 : bus.src2;
        sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, bus.cin};
        add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        unique case (bus.operation)
            3'b000: alu_res = a & b;
            3'b001: alu_res = a | b;
            3'b010: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = add_ovf;
            end
            3'b011: begin
                // True sign of the un-wrapped sum: MSB corrected by overflow.
                alu_res  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
                alu_cout = sum[WIDTH];
                alu_ovf  = add_ovf;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (is_mul) begin
                        state_d  = StCalc;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        cnt_d    = '0;
                    end else begin
                        state_d  = StDone;
                        result_d = alu_res;
                        cout_d   = alu_cout;
                        ovf_d    = alu_ovf;
                        zero_d   = (alu_res == '0);
                    end
                end
            end
            StCalc: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d  = StDone;
                    cnt_d    = '0;
                    result_d = acc_step[WIDTH-1:0];
                    cout_d   = |acc_step[2*WIDTH-1:WIDTH];
                    ovf_d    = |acc_step[2*WIDTH-1:WIDTH];
                    zero_d   = (acc_step[WIDTH-1:0] == '0);
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=8, MUL_EN=1).
// A transaction-level reference model (plain integer arithmetic) predicts handshakes and
// results every cycle; directed operations pin literal values, latency, backpressure and
// mid-operation reset, followed by a randomized stream.
module tb_alu_seq;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the operation must produce, from plain signed/unsigned arithmetic.
    task automatic ref_op(input logic [7:0] s1, input logic [7:0] s2, input bit ai, input bit bi,
                          input bit ci, input logic [2:0] op, output logic [7:0] r,
                          output bit co, output bit ov, output bit z);
        logic [7:0] av, bv;
        int a, b, sa, sb, s, ss, p;
        av = ai ? ~s1 : s1;
        bv = bi ? ~s2 : s2;
        a  = int'(av);
        b  = int'(bv);
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        s  = a + b + int'(ci);
        ss = sa + sb + int'(ci);
        r  = 8'h00;
        co = 1'b0;
        ov = 1'b0;
        case (op)
            3'd0: r = 8'(a & b);
            3'd1: r = 8'(a | b);
            3'd2: begin
                r  = 8'(s % 256);
                co = (s >= 256);
                ov = (ss > 127) || (ss < -128);
            end
            3'd3: begin
                r  = (ss < 0) ? 8'h01 : 8'h00;
                co = (s >= 256);
                ov = (ss > 127) || (ss < -128);
            end
            3'd4: begin
                p  = a * b;
                r  = 8'(p % 256);
                co = (p >= 256);
                ov = (p >= 256);
            end
            default: ;
        endcase
        z = (r == 8'h00);
    endtask

    // Cycle-by-cycle compare against the model; inputs are stable at the falling edge.
    typedef enum {MIdle, MBusy, MDone} mstate_t;
    mstate_t    m_st = MIdle;
    int         m_wait = 0;
    logic [7:0] m_res = 8'h00;
    bit         m_co = 1'b0, m_ov = 1'b0, m_z = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", longint'(bus.in_ready), longint'(m_st == MIdle && !rst));
            check("out_valid", longint'(bus.out_valid), longint'(m_st == MDone));
            if (m_st == MDone) begin
                check("result", longint'(bus.result), longint'(m_res));
                check("cout", longint'(bus.cout), longint'(m_co));
                check("overflow", longint'(bus.overflow), longint'(m_ov));
                check("zero", longint'(bus.zero), longint'(m_z));
            end
            if (rst) begin
                m_st = MIdle;
            end else begin
                case (m_st)
                    MIdle: if (bus.in_valid) begin
                        ref_op(bus.src1, bus.src2, bus.A_invert, bus.B_invert, bus.cin,
                               bus.operation, m_res, m_co, m_ov, m_z);
                        if (bus.operation == 3'd4) begin
                            m_st   = MBusy;
                            m_wait = W;
                        end else begin
                            m_st = MDone;
                        end
                    end
                    MBusy: begin
                        m_wait--;
                        if (m_wait == 0) m_st = MDone;
                    end
                    MDone: if (bus.out_ready) m_st = MIdle;
                    default: m_st = MIdle;
                endcase
            end
        end
    end

    task automatic drive_req(input logic [7:0] s1, input logic [7:0] s2, input bit ai,
                             input bit bi, input bit ci, input logic [2:0] op);
        bus.src1      = s1;
        bus.src2      = s2;
        bus.A_invert  = ai;
        bus.B_invert  = bi;
        bus.cin       = ci;
        bus.operation = op;
        bus.in_valid  = 1'b1;
    endtask

    // Returns with the accepting edge just passed (#1 after it) and in_valid dropped.
    task automatic wait_accept(input string name, output bit ok);
        int guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        ok = bus.in_ready;
        if (!ok) check({name, "_accept_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        // Scramble operands after acceptance: the operation must not see them.
        bus.src1 = 8'($urandom);
        bus.src2 = 8'($urandom);
        bus.A_invert = 1'($urandom);
        bus.B_invert = 1'($urandom);
        bus.cin = 1'($urandom);
    endtask

    task automatic do_op(input string name, input logic [7:0] s1, input logic [7:0] s2,
                         input bit ai, input bit bi, input bit ci, input logic [2:0] op,
                         input logic [7:0] er, input bit eco, input bit eov, input bit ez,
                         input int elat, input int hold);
        bit ok;
        int lat;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        drive_req(s1, s2, ai, bi, ci, op);
        wait_accept(name, ok);
        if (!ok) return;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 50);
        check({name, "_latency"}, longint'(lat), longint'(elat));
        check({name, "_result"}, longint'(bus.result), longint'(er));
        check({name, "_cout"}, longint'(bus.cout), longint'(eco));
        check({name, "_overflow"}, longint'(bus.overflow), longint'(eov));
        check({name, "_zero"}, longint'(bus.zero), longint'(ez));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.src1 = 8'($urandom);
            bus.src2 = 8'($urandom);
            @(negedge clk);
            check({name, "_hold_result"}, longint'(bus.result), longint'(er));
            check({name, "_hold_in_ready"}, longint'(bus.in_ready), 0);
            check({name, "_hold_out_valid"}, longint'(bus.out_valid), 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check({name, "_idle_after"}, longint'(bus.in_ready), 1);
        check({name, "_no_valid_after"}, longint'(bus.out_valid), 0);
    endtask

    task automatic abort_mul();
        bit ok;
        @(posedge clk);
        #1;
        drive_req(8'h0C, 8'h0B, 1'b0, 1'b0, 1'b0, 3'd4);
        wait_accept("abort_mul", ok);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", longint'(bus.in_ready), 1);
        for (int i = 0; i < 12; i++) begin
            check("abort_no_valid", longint'(bus.out_valid), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.A_invert  = 1'b0;
        bus.B_invert  = 1'b0;
        bus.cin       = 1'b0;
        bus.operation = 3'd0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", longint'(bus.in_ready), 0);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_result", longint'(bus.result), 0);
        check("rst_cout", longint'(bus.cout), 0);
        check("rst_zero", longint'(bus.zero), 0);
        check("rst_overflow", longint'(bus.overflow), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //     name        src1   src2   ai bi ci op    res    co ov z  lat hold
        do_op("and",      8'h96, 8'hDB, 0, 0, 0, 3'd0, 8'h92, 0, 0, 0, 1, 0);
        do_op("or",       8'h2E, 8'hC5, 0, 0, 0, 3'd1, 8'hEF, 0, 0, 0, 1, 0);
        do_op("add",      8'h6C, 8'h91, 0, 0, 0, 3'd2, 8'hFD, 0, 0, 0, 1, 0);
        do_op("add_ovf",  8'h7F, 8'h01, 0, 0, 0, 3'd2, 8'h80, 0, 1, 0, 1, 0);
        do_op("add_cin",  8'hF0, 8'hB0, 0, 0, 1, 3'd2, 8'hA1, 1, 0, 0, 1, 0);
        do_op("slt_neg",  8'hF0, 8'h10, 0, 1, 1, 3'd3, 8'h01, 1, 0, 0, 1, 0);
        do_op("slt_ovf",  8'h80, 8'h01, 0, 1, 1, 3'd3, 8'h01, 1, 1, 0, 1, 0);
        do_op("slt_ge",   8'h10, 8'hF0, 0, 1, 1, 3'd3, 8'h00, 0, 0, 1, 1, 0);
        do_op("mul",      8'h0C, 8'h0B, 0, 0, 0, 3'd4, 8'h84, 0, 0, 0, 9, 0);
        do_op("mul_hi",   8'h10, 8'h10, 0, 0, 0, 3'd4, 8'h00, 1, 1, 1, 9, 0);
        do_op("reserved", 8'h55, 8'h33, 0, 0, 1, 3'd6, 8'h00, 0, 0, 1, 1, 0);
        do_op("and_inv",  8'h0F, 8'h3C, 1, 0, 0, 3'd0, 8'h30, 0, 0, 0, 1, 0);
        do_op("backpr",   8'h6C, 8'h91, 0, 0, 0, 3'd2, 8'hFD, 0, 0, 0, 1, 5);
        abort_mul();
        do_op("post_rst", 8'h01, 8'h01, 0, 0, 0, 3'd2, 8'h02, 0, 0, 0, 1, 0);

        // Randomized stream, biased towards MUL, with rare resets; the model checks it.
        repeat (2000) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.src1      = 8'($urandom);
            bus.src2      = 8'($urandom);
            bus.A_invert  = 1'($urandom);
            bus.B_invert  = 1'($urandom);
            bus.cin       = 1'($urandom);
            bus.operation = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
